// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register with LD/RDY load handshake.
// Emits one bit per clock on Q/nQ, framed by VLD and LAST.
module piso_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             C,
    input  logic             nR,
    input  logic [WIDTH-1:0] P,
    input  logic             LD,
    output logic             RDY,
    output logic             Q,
    output logic             nQ,
    output logic             VLD,
    output logic             LAST
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic [WIDTH-1:0] sreg_shifted;

    assign VLD    = (state_q == SHIFT);
    assign LAST   = VLD && (cnt_q == CNT_MAX);
    assign RDY    = !VLD || LAST;
    assign accept = LD && RDY;

    // Q is gated so that IDLE never shows a stale bit.
    assign Q  = VLD & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
    assign nQ = ~Q;

    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SHIFT;
            sreg_d  = P;
            cnt_d   = '0;
        end else if (LAST) begin
            state_d = IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
        end else if (VLD) begin
            sreg_d  = sreg_shifted;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge C) begin
        if (!nR) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Directed bench for piso_shift_reg: MSB/LSB-first instances and a
// WIDTH=2 loopback into a two-stage serial-in receiver model.
module tb_piso_shift_reg;

    logic       clk = 1'b0;
    logic       nr;
    logic [3:0] pa, pb;
    logic [1:0] pc;
    logic       lda, ldb, ldc;
    logic       rdya, qa, nqa, vlda, lasta;
    logic       rdyb, qb, nqb, vldb, lastb;
    logic       rdyc, qc, nqc, vldc, lastc;
    logic       rx1, rx2;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b1)) u_a (
        .C(clk), .nR(nr), .P(pa), .LD(lda), .RDY(rdya),
        .Q(qa), .nQ(nqa), .VLD(vlda), .LAST(lasta)
    );

    piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b0)) u_b (
        .C(clk), .nR(nr), .P(pb), .LD(ldb), .RDY(rdyb),
        .Q(qb), .nQ(nqb), .VLD(vldb), .LAST(lastb)
    );

    piso_shift_reg #(.WIDTH(2), .MSB_FIRST(1'b1)) u_c (
        .C(clk), .nR(nr), .P(pc), .LD(ldc), .RDY(rdyc),
        .Q(qc), .nQ(nqc), .VLD(vldc), .LAST(lastc)
    );

    // Receiver: shift_REG_2bits behaviour, Q1 <= D, Q2 <= Q1.
    always_ff @(posedge clk) begin
        if (!nr) begin
            rx1 <= 1'b0;
            rx2 <= 1'b0;
        end else begin
            rx1 <= qc;
            rx2 <= rx1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs,
                       input logic [4:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Packed as {Q, nQ, VLD, LAST, RDY}.
    function automatic logic [4:0] oa();
        return {qa, nqa, vlda, lasta, rdya};
    endfunction

    function automatic logic [4:0] ob();
        return {qb, nqb, vldb, lastb, rdyb};
    endfunction

    initial begin
        nr = 1'b0;
        lda = 1'b1; pa = 4'hF;
        ldb = 1'b1; pb = 4'hF;
        ldc = 1'b0; pc = 2'b00;
        step();
        step();
        chk("rst_a", oa(), 5'b01001);
        chk("rst_b", ob(), 5'b01001);
        nr = 1'b1; lda = 1'b0; ldb = 1'b0;
        step();
        chk("rst_nocap", oa(), 5'b01001);

        // Single word 1011
        lda = 1'b1; pa = 4'b1011;
        step(); chk("w1_b1", oa(), 5'b10100);
        lda = 1'b0; pa = 4'b0000;
        step(); chk("w1_b2", oa(), 5'b01100);
        step(); chk("w1_b3", oa(), 5'b10100);
        step(); chk("w1_b4", oa(), 5'b10111);
        step(); chk("w1_idle", oa(), 5'b01001);

        // Back-to-back 1011 then 0110
        lda = 1'b1; pa = 4'b1011;
        step(); chk("bb_b1", oa(), 5'b10100);
        step(); chk("bb_b2", oa(), 5'b01100);
        step(); chk("bb_b3", oa(), 5'b10100);
        step(); chk("bb_b4", oa(), 5'b10111);
        pa = 4'b0110;
        step(); chk("bb_b5", oa(), 5'b01100);
        lda = 1'b0; pa = 4'b0000;
        step(); chk("bb_b6", oa(), 5'b10100);
        step(); chk("bb_b7", oa(), 5'b10100);
        step(); chk("bb_b8", oa(), 5'b01111);
        step(); chk("bb_idle", oa(), 5'b01001);

        // Busy load ignored
        lda = 1'b1; pa = 4'b1011;
        step(); chk("busy_b1", oa(), 5'b10100);
        lda = 1'b0;
        step(); chk("busy_b2", oa(), 5'b01100);
        lda = 1'b1; pa = 4'b0000;
        step(); chk("busy_b3", oa(), 5'b10100);
        lda = 1'b0;
        step(); chk("busy_b4", oa(), 5'b10111);
        step(); chk("busy_idle", oa(), 5'b01001);

        // Reset mid-word, then fresh load 1100
        lda = 1'b1; pa = 4'b1011;
        step(); chk("mr_b1", oa(), 5'b10100);
        lda = 1'b0;
        step(); chk("mr_b2", oa(), 5'b01100);
        nr = 1'b0;
        step(); chk("mr_rst", oa(), 5'b01001);
        nr = 1'b1; lda = 1'b1; pa = 4'b1100;
        step(); chk("mr_n1", oa(), 5'b10100);
        lda = 1'b0;
        step(); chk("mr_n2", oa(), 5'b10100);
        step(); chk("mr_n3", oa(), 5'b01100);
        step(); chk("mr_n4", oa(), 5'b01111);
        step(); chk("mr_idle", oa(), 5'b01001);

        // LSB-first 1011 -> 1,1,0,1
        ldb = 1'b1; pb = 4'b1011;
        step(); chk("lsb_b1", ob(), 5'b10100);
        ldb = 1'b0;
        step(); chk("lsb_b2", ob(), 5'b10100);
        step(); chk("lsb_b3", ob(), 5'b01100);
        step(); chk("lsb_b4", ob(), 5'b10111);
        step(); chk("lsb_idle", ob(), 5'b01001);

        // WIDTH=2 loopback, P=10
        ldc = 1'b1; pc = 2'b10;
        step();
        chk("lb_b1", {qc, nqc, vldc, lastc, rdyc}, 5'b10100);
        ldc = 1'b0;
        step();
        chk("lb_b2", {qc, nqc, vldc, lastc, rdyc}, 5'b01111);
        step();
        chk("lb_rx", {3'b000, rx1, rx2}, 5'b00001);
        chk("lb_idle", {qc, nqc, vldc, lastc, rdyc}, 5'b01001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/piso_shift_reg.md
# piso_shift_reg

Parallel-in, serial-out shift register with a load handshake: captures a WIDTH-bit word and emits it one bit per clock on Q/nQ. It is the transmit-side counterpart to the serial-in, parallel-out shift register chain (`shift_REG_2bits`) and drives that register's D input in loopback benches. Each word is framed by VLD/LAST, and RDY allows back-to-back words with no idle cycle.

## Interface
Parameters:
- WIDTH, 4, word length in bits; legal values ≥ 2.
- MSB_FIRST, 1, 1 = P[WIDTH-1] is emitted first; 0 = P[0] is emitted first.

Ports:
- C  in  1  clock; all state changes on the rising edge.
- nR  in  1  reset; synchronous, active-low.
- P  in  WIDTH  parallel word; sampled only on an accepted load.
- LD  in  1  load request.
- RDY  out  1  block can accept a load this cycle.
- Q  out  1  serial data bit.
- nQ  out  1  always the complement of Q.
- VLD  out  1  Q carries a valid data bit.
- LAST  out  1  Q carries the final bit of the word.

## Operation
- Internal state:
  - FSM state: IDLE or SHIFT.
  - Shift register sreg[WIDTH-1:0].
  - Bit counter cnt, $clog2(WIDTH) bits wide, range 0..WIDTH-1.
- Reset (nR=0 at a rising edge) sets state=IDLE, sreg=0, cnt=0. Resulting outputs: Q=0, nQ=1, VLD=0, LAST=0, RDY=1.
- nR has priority over LD. A reset during SHIFT aborts the word; the remaining bits are never emitted.
- Output decode (combinational from registers):
  - Q = sreg[WIDTH-1] when MSB_FIRST=1, sreg[0] otherwise; Q is forced to 0 in IDLE.
  - VLD = (state==SHIFT).
  - LAST = (state==SHIFT) && (cnt==WIDTH-1).
  - RDY = (state==IDLE) || LAST.
- Accept = LD && RDY at a rising edge. On accept: sreg←P, cnt←0, state←SHIFT.
- SHIFT, cnt<WIDTH-1, at each edge:
  - MSB_FIRST=1: sreg shifts left with 0 fill.
  - MSB_FIRST=0: sreg shifts right with 0 fill.
  - cnt←cnt+1.
- SHIFT, cnt==WIDTH-1 (LAST=1), at the edge:
  - If accept: reload as above and stay in SHIFT.
  - Otherwise: state←IDLE, sreg←0, cnt←0.
- LD asserted while RDY=0 is ignored. P is not captured and no state changes; the source must hold LD until RDY.
- cnt never wraps past WIDTH-1.

## Timing
- Latency: the first bit appears on Q in the cycle immediately after the accepting edge.
- A word occupies exactly WIDTH consecutive VLD cycles.
- LAST is high for exactly one cycle per word (the final bit).
- Throughput: with LD held high, one word every WIDTH cycles and VLD stays continuously high.
- Receiver-side sampling: Q is stable for a full clock period and is sampled at the rising C edge that ends its cycle.
- nQ changes in the same cycle as Q; there is no skew between them at RTL level.

## Test plan
- Reset: hold nR=0 for 2 edges with LD=1, P=4'hF. Then Q=0, nQ=1, VLD=0, LAST=0, RDY=1, and nothing is captured.
- Single word, WIDTH=4, MSB_FIRST=1, P=4'b1011, LD for 1 cycle:
  - Q=1,0,1,1 over the next 4 cycles; nQ is the complement each cycle.
  - VLD high for 4 cycles; LAST only in cycle 4.
  - Then IDLE with Q=0 and RDY=1.
- Back-to-back: LD held high, P=4'b1011 then 4'b0110 (change P during the LAST cycle):
  - Q=1,0,1,1,0,1,1,0.
  - VLD high for 8 contiguous cycles; LAST in cycles 4 and 8.
- Busy load ignored: during bit 2 of 4'b1011, pulse LD with P=4'b0000. The stream stays 1,0,1,1 and returns to IDLE afterwards.
- Reset mid-word: assert nR=0 during bit 2. The next cycle shows VLD=0, Q=0, RDY=1, and a fresh load of 4'b1100 emits 1,1,0,0.
- LSB-first and loopback:
  - MSB_FIRST=0, P=4'b1011 gives Q=1,1,0,1.
  - WIDTH=2, Q wired to `shift_REG_2bits` D: after 2 VLD cycles with P=2'b10, the receiver holds Q1=0, Q2=1.
